dma_req_scheduler: RTL and testbench

- Shares the NUM_CH hard DMA request/acknowledge channels of the SoC–FPGA DMA interface between NUM_REQ fabric requesters.
- Each requester posts a transfer of N beats. The block grants round-robin, binds the winner to the lowest free channel, and drives that channel's DMA_REQ until N acknowledge beats are counted.
- Completion or timeout is reported back to the requester.
- Sits in the fabric between user DMA clients and the DMA interface primitive, on the DMA clock.

---
 rtl/dma_sched_pkg.sv | 14 +
 rtl/dma_rr_arbiter.sv | 51 +++++
 rtl/dma_req_scheduler.sv | 120 ++++++++++++
 tb/tb_dma_req_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// rtl/dma_sched_pkg.sv - shared channel state type and widths for the DMA request scheduler
package dma_sched_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ACTIVE,
    CH_DONE,
    CH_ERR
  } ch_state_e;

  localparam int OWN_W       = 4;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/dma_rr_arbiter.sv
// rtl/dma_rr_arbiter.sv - round-robin pick of one requester per cycle, pointer advances past the winner
module dma_rr_arbiter
  import dma_sched_pkg::*;
#(
  parameter int NUM_REQ = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [OWN_W-1:0]   gnt_idx_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] cand;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    ptr_d = ptr_q;
    if (found && en_i) begin
      gnt_o[win] = 1'b1;
      ptr_d      = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    end
  end

  assign gnt_idx_o = OWN_W'(win);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dma_req_scheduler.sv
// rtl/dma_req_scheduler.sv - binds round-robin winners to the lowest idle DMA channel and
// drives DMA_REQ until the requested number of acknowledge beats has been seen
module dma_req_scheduler
  import dma_sched_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int NUM_CH  = 4,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      DMA_CLK,
  input  logic                      DMA_RST_N,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ*LEN_W-1:0]  REQ_LEN,
  output logic [NUM_REQ-1:0]        REQ_READY,
  output logic [NUM_REQ-1:0]        REQ_DONE,
  output logic [NUM_REQ-1:0]        REQ_ERR,
  output logic [NUM_CH-1:0]         DMA_REQ,
  input  logic [NUM_CH-1:0]         DMA_ACK,
  output logic [NUM_CH-1:0]         CH_BUSY,
  output logic [NUM_CH*OWN_W-1:0]   CH_OWNER
);

  localparam int TW = $clog2(TIMEOUT);

  logic [NUM_CH-1:0]             ch_idle, ch_done, ch_err, ch_gnt;
  logic [NUM_CH-1:0][OWN_W-1:0]  ch_own;
  logic [NUM_REQ-1:0]            owns, eligible, gnt;
  logic [OWN_W-1:0]              gnt_idx;
  logic [LEN_W-1:0]              gnt_len;
  logic                          gnt_en;

  always_comb begin
    owns     = '0;
    REQ_DONE = '0;
    REQ_ERR  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_own[c] == OWN_W'(i)) begin
          if (CH_BUSY[c]) owns[i]     = 1'b1;
          if (ch_done[c]) REQ_DONE[i] = 1'b1;
          if (ch_err[c])  REQ_ERR[i]  = 1'b1;
        end
      end
    end
  end

  assign eligible = REQ_VALID & ~owns;
  // Grants are suppressed while reset is asserted so REQ_READY stays low then.
  assign gnt_en   = DMA_RST_N & (|ch_idle);

  dma_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i     (DMA_CLK),
    .rst_ni    (DMA_RST_N),
    .en_i      (gnt_en),
    .req_i     (eligible),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign REQ_READY = gnt;
  assign ch_gnt    = (|gnt) ? (ch_idle & (~ch_idle + NUM_CH'(1))) : '0;

  always_comb begin
    gnt_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_len = REQ_LEN[i*LEN_W +: LEN_W];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e         state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [TW-1:0]     timer_q;
    logic [OWN_W-1:0]  own_q;

    always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
      if (!DMA_RST_N) begin
        state_q <= CH_IDLE;
        rem_q   <= '0;
        timer_q <= '0;
        own_q   <= '0;
      end else begin
        case (state_q)
          CH_IDLE: begin
            if (ch_gnt[c]) begin
              own_q   <= gnt_idx;
              rem_q   <= gnt_len;
              timer_q <= '0;
              state_q <= (gnt_len == '0) ? CH_DONE : CH_ACTIVE;
            end
          end
          CH_ACTIVE: begin
            if (DMA_ACK[c]) begin
              rem_q   <= rem_q - LEN_W'(1);
              timer_q <= '0;
              if (rem_q == LEN_W'(1)) state_q <= CH_DONE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
              state_q <= CH_ERR;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          default: state_q <= CH_IDLE;
        endcase
      end
    end

    assign ch_idle[c] = (state_q == CH_IDLE);
    assign ch_done[c] = (state_q == CH_DONE);
    assign ch_err[c]  = (state_q == CH_ERR);
    assign DMA_REQ[c] = (state_q == CH_ACTIVE);
    assign CH_BUSY[c] = (state_q != CH_IDLE);
    assign ch_own[c]  = own_q;
    assign CH_OWNER[c*OWN_W +: OWN_W] = (state_q != CH_IDLE) ? own_q : '0;
  end

endmodule

// File: tb/tb_dma_req_scheduler.sv
// tb/tb_dma_req_scheduler.sv - directed self-checking bench for dma_req_scheduler
module tb_dma_req_scheduler;

  localparam int NR = 8;
  localparam int NC = 4;
  localparam int LW = 8;
  localparam int TO = 64;

  logic              DMA_CLK = 1'b0;
  logic              DMA_RST_N;
  logic [NR-1:0]     REQ_VALID;
  logic [NR*LW-1:0]  REQ_LEN;
  logic [NR-1:0]     REQ_READY, REQ_DONE, REQ_ERR;
  logic [NC-1:0]     DMA_REQ, DMA_ACK, CH_BUSY;
  logic [NC*4-1:0]   CH_OWNER;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0] pending;
  logic [LW-1:0] plen [NR];
  logic          auto_ack;
  logic [NC-1:0] man_ack, prev_req;

  dma_req_scheduler #(
    .NUM_REQ (NR),
    .NUM_CH  (NC),
    .LEN_W   (LW),
    .TIMEOUT (TO)
  ) dut (
    .DMA_CLK   (DMA_CLK),
    .DMA_RST_N (DMA_RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_LEN   (REQ_LEN),
    .REQ_READY (REQ_READY),
    .REQ_DONE  (REQ_DONE),
    .REQ_ERR   (REQ_ERR),
    .DMA_REQ   (DMA_REQ),
    .DMA_ACK   (DMA_ACK),
    .CH_BUSY   (CH_BUSY),
    .CH_OWNER  (CH_OWNER)
  );

  always #5 DMA_CLK = ~DMA_CLK;

  // One cycle: drive at the falling edge, let REQ_READY settle, retire granted requests.
  task automatic cyc();
    @(negedge DMA_CLK);
    DMA_ACK   = auto_ack ? prev_req : man_ack;
    prev_req  = DMA_REQ;
    REQ_VALID = pending;
    for (int i = 0; i < NR; i++) REQ_LEN[i*LW +: LW] = plen[i];
    #1;
    pending = pending & ~REQ_READY;
  endtask

  task automatic do_reset();
    pending   = '0;
    auto_ack  = 1'b0;
    man_ack   = '0;
    prev_req  = '0;
    REQ_VALID = '0;
    DMA_ACK   = '0;
    for (int i = 0; i < NR; i++) plen[i] = '0;
    @(negedge DMA_CLK);
    DMA_RST_N = 1'b0;
    repeat (2) @(negedge DMA_CLK);
    DMA_RST_N = 1'b1;
  endtask

  task automatic test_reset();
    DMA_RST_N = 1'b0;
    REQ_VALID = '1;
    REQ_LEN   = '1;
    DMA_ACK   = '1;
    #3;
    checks++;
    if (REQ_READY !== '0) begin errors++; $display("FAIL reset_ready: got %h expected 00", REQ_READY); end
    checks++;
    if ({REQ_DONE, REQ_ERR} !== '0) begin errors++; $display("FAIL reset_pulses: got %h expected 0000", {REQ_DONE, REQ_ERR}); end
    checks++;
    if (DMA_REQ !== '0) begin errors++; $display("FAIL reset_dma_req: got %h expected 0", DMA_REQ); end
    checks++;
    if (CH_BUSY !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", CH_BUSY); end
    checks++;
    if (CH_OWNER !== '0) begin errors++; $display("FAIL reset_owner: got %h expected 0000", CH_OWNER); end
  endtask

  task automatic test_single();
    int rdy_n = 0, rdy_c = -1, hi = 0, beats = 0, dn = 0, dn_c = -1, er = 0, trail = 0;
    do_reset();
    auto_ack   = 1'b1;
    plen[0]    = 8'd3;
    pending[0] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      cyc();
      if (REQ_READY[0]) begin rdy_n++; rdy_c = t; end
      if (DMA_REQ[0]) hi++;
      if (DMA_REQ[0] && DMA_ACK[0]) beats++;
      if (!DMA_REQ[0] && DMA_ACK[0]) trail++;
      if (REQ_DONE[0]) begin dn++; dn_c = t; end
      if (|REQ_ERR) er++;
    end
    checks++;
    if (rdy_n !== 1 || rdy_c !== 1) begin errors++; $display("FAIL single_ready: got %0d pulses at cycle %0d expected 1 at cycle 1", rdy_n, rdy_c); end
    checks++;
    if (hi !== 4) begin errors++; $display("FAIL single_req_cycles: got %0d expected 4", hi); end
    checks++;
    if (beats !== 3) begin errors++; $display("FAIL single_beats: got %0d expected 3", beats); end
    checks++;
    if (dn !== 1 || dn_c !== 6) begin errors++; $display("FAIL single_done: got %0d pulses at cycle %0d expected 1 at cycle 6", dn, dn_c); end
    checks++;
    if (er !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", er); end
    checks++;
    if (trail !== 1) begin errors++; $display("FAIL single_trailing_ack: got %0d expected 1", trail); end
    checks++;
    if (CH_BUSY !== '0) begin errors++; $display("FAIL single_busy_end: got %h expected 0", CH_BUSY); end
  endtask

  task automatic test_round_robin();
    int exp_cyc [8] = '{1, 2, 3, 4, 8, 9, 10, 11};
    int exp_ch  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int g_idx [8], g_cyc [8], c_ch [8], c_own [8];
    int rdy_per [8], done_per [8];
    int ng = 0, nc = 0;
    logic [NC-1:0] pbusy = '0;
    logic once_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      g_idx[k] = -1; g_cyc[k] = -1; c_ch[k] = -1; c_own[k] = -1; rdy_per[k] = 0; done_per[k] = 0;
    end
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < NR; i++) plen[i] = 8'd4;
    pending = '1;
    for (int t = 1; t <= 32; t++) begin
      cyc();
      for (int i = 0; i < NR; i++) begin
        if (REQ_READY[i]) begin
          rdy_per[i]++;
          if (ng < 8) begin g_idx[ng] = i; g_cyc[ng] = t; end
          ng++;
        end
        if (REQ_DONE[i]) done_per[i]++;
      end
      for (int c = 0; c < NC; c++) begin
        if (CH_BUSY[c] && !pbusy[c]) begin
          if (nc < 8) begin c_ch[nc] = c; c_own[nc] = int'(CH_OWNER[c*4 +: 4]); end
          nc++;
        end
      end
      pbusy = CH_BUSY;
    end
    checks++;
    if (ng !== 8) begin errors++; $display("FAIL rr_grant_count: got %0d expected 8", ng); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (g_idx[k] !== k || g_cyc[k] !== exp_cyc[k]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got req %0d at cycle %0d expected req %0d at cycle %0d", k, g_idx[k], g_cyc[k], k, exp_cyc[k]);
      end
      checks++;
      if (c_ch[k] !== exp_ch[k] || c_own[k] !== k) begin
        errors++;
        $display("FAIL rr_bind_%0d: got ch %0d owner %0d expected ch %0d owner %0d", k, c_ch[k], c_own[k], exp_ch[k], k);
      end
    end
    for (int k = 0; k < 8; k++) if (rdy_per[k] != 1 || done_per[k] != 1) once_ok = 1'b0;
    checks++;
    if (once_ok !== 1'b1) begin errors++; $display("FAIL rr_once_each: got %b expected 1", once_ok); end
  endtask

  task automatic test_zero_len();
    int rc = -1, dc = -1, dn = 0, hi = 0;
    do_reset();
    auto_ack   = 1'b1;
    plen[5]    = 8'd0;
    pending[5] = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      cyc();
      if (REQ_READY[5]) rc = t;
      if (REQ_DONE[5]) begin dn++; dc = t; end
      if (|DMA_REQ) hi++;
    end
    checks++;
    if (rc !== 1) begin errors++; $display("FAIL zero_ready: got cycle %0d expected 1", rc); end
    checks++;
    if (dn !== 1 || dc !== 2) begin errors++; $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at cycle 2", dn, dc); end
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL zero_dma_req: got %0d cycles expected 0", hi); end
  endtask

  task automatic test_timeout();
    int hi = 0, ec = -1, en = 0, dn = 0;
    do_reset();
    plen[2]    = 8'd5;
    pending[2] = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      cyc();
      if (DMA_REQ[0]) hi++;
      if (REQ_ERR[2]) begin en++; ec = t; end
      if (|REQ_DONE) dn++;
    end
    checks++;
    if (hi !== TO) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected %0d", hi, TO); end
    checks++;
    if (en !== 1 || ec !== 66) begin errors++; $display("FAIL timeout_err: got %0d pulses at cycle %0d expected 1 at cycle 66", en, ec); end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL timeout_done: got %0d expected 0", dn); end
    checks++;
    if (CH_BUSY !== '0) begin errors++; $display("FAIL timeout_busy_end: got %h expected 0", CH_BUSY); end
  endtask

  task automatic test_reset_mid();
    int beats = 0, bad = 0, first = -1, d0 = 0, d1 = 0;
    do_reset();
    auto_ack   = 1'b1;
    plen[0]    = 8'd10;
    pending[0] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      cyc();
      if (DMA_REQ[0] && DMA_ACK[0]) beats++;
      if (beats == 4) break;
    end
    checks++;
    if (beats !== 4) begin errors++; $display("FAIL rmid_reach_beat4: got %0d expected 4", beats); end
    #2;
    REQ_VALID = 8'h03;
    DMA_RST_N = 1'b0;
    #1;
    checks++;
    if (DMA_REQ !== '0 || CH_BUSY !== '0) begin errors++; $display("FAIL rmid_drop: got req %h busy %h expected 0 0", DMA_REQ, CH_BUSY); end
    checks++;
    if ({REQ_READY, REQ_DONE, REQ_ERR} !== '0) begin errors++; $display("FAIL rmid_pulses: got %h expected 0", {REQ_READY, REQ_DONE, REQ_ERR}); end
    repeat (3) begin
      @(negedge DMA_CLK);
      #1;
      if ((|REQ_DONE) || (|REQ_ERR) || (|REQ_READY) || (|DMA_REQ)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rmid_held: got %0d active cycles expected 0", bad); end
    pending   = '0;
    REQ_VALID = '0;
    prev_req  = '0;
    @(negedge DMA_CLK);
    DMA_RST_N = 1'b1;
    plen[0]   = 8'd2;
    plen[1]   = 8'd2;
    pending   = 8'h03;
    for (int t = 1; t <= 20; t++) begin
      cyc();
      if (first < 0) begin
        if (REQ_READY[0]) first = 0;
        else if (REQ_READY[1]) first = 1;
      end
      if (REQ_DONE[0]) d0++;
      if (REQ_DONE[1]) d1++;
    end
    checks++;
    if (first !== 0) begin errors++; $display("FAIL rmid_ptr_zero: got first grant %0d expected 0", first); end
    checks++;
    if (d0 !== 1 || d1 !== 1) begin errors++; $display("FAIL rmid_served: got done %0d/%0d expected 1/1", d0, d1); end
  endtask

  task automatic test_ack_gating();
    int busy_seen = 0, pulse_seen = 0, rdy4 = 0, own4 = 0, dn = 0, errs = 0, err4 = 0;
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      man_ack = NC'($urandom);
      cyc();
      if ((|CH_BUSY) || (|DMA_REQ)) busy_seen++;
      if ((|REQ_DONE) || (|REQ_ERR) || (|REQ_READY)) pulse_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin errors++; $display("FAIL gate_idle_busy: got %0d cycles expected 0", busy_seen); end
    checks++;
    if (pulse_seen !== 0) begin errors++; $display("FAIL gate_idle_pulses: got %0d cycles expected 0", pulse_seen); end
    man_ack = '0;
    for (int i = 0; i < 4; i++) plen[i] = 8'd200;
    plen[4] = 8'd3;
    pending = 8'h0F;
    for (int t = 1; t <= 80; t++) begin
      if (t == 5)  pending[4] = 1'b1;
      if (t == 11) pending[4] = 1'b0;
      cyc();
      if (REQ_READY[4]) rdy4++;
      for (int c = 0; c < NC; c++) if (CH_BUSY[c] && CH_OWNER[c*4 +: 4] == 4'd4) own4++;
      if (|REQ_DONE) dn++;
      for (int i = 0; i < 4; i++) if (REQ_ERR[i]) errs++;
      if (REQ_ERR[4]) err4++;
    end
    checks++;
    if (rdy4 !== 0 || own4 !== 0) begin errors++; $display("FAIL gate_withdrawn: got ready %0d owned %0d expected 0 0", rdy4, own4); end
    checks++;
    if (dn !== 0 || err4 !== 0) begin errors++; $display("FAIL gate_withdrawn_pulses: got done %0d err4 %0d expected 0 0", dn, err4); end
    checks++;
    if (errs !== 4) begin errors++; $display("FAIL gate_timeouts: got %0d expected 4", errs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_ack_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
